signed_bar_display: RTL and testbench

Parametrised, registered successor to the combinational 3-bit signed thermometer decoder. It drives a centre-anchored LED bar of 2·HALF+1 segments from a W-bit two's-complement sample. The bar grows right for positive values and left for negative ones, with saturation, optional slew limiting (one segment per tick) and an optional peak-hold marker with timed decay. It sits between the sample source and the board LED pins.

---
 rtl/signed_bar_pkg.sv | 24 ++
 rtl/bar_mask.sv | 27 ++
 rtl/signed_bar_display.sv | 110 +++++++++++
 tb/tb_signed_bar_display.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/signed_bar_pkg.sv
// Shared types and helpers for the signed LED bar display:
// level width, sample-to-level mapping and the peak-marker state enum.
package signed_bar_pkg;

  typedef enum logic [1:0] {
    PK_TRACK,
    PK_HOLD,
    PK_DECAY
  } peak_state_t;

  // Enough bits to hold -HALF..+HALF as a signed value.
  function automatic int level_width(input int half);
    return $clog2(half + 1) + 1;
  endfunction

  // The most-negative code is reserved as "invalid" and shows as centre only.
  function automatic int map_level(input int v, input int w, input int half);
    if (v == -(1 << (w - 1))) return 0;
    if (v > half) return half;
    if (v < -half) return -half;
    return v;
  endfunction

endpackage

// File: rtl/bar_mask.sv
// Level to centre-anchored segment mask: a full thermometer bar, or only
// the tip segment when TIP_ONLY is set (used for the peak marker).
module bar_mask #(
  parameter int HALF     = 3,
  parameter int LW       = 3,
  parameter bit TIP_ONLY = 1'b0
) (
  input  logic signed [LW-1:0] level,
  output logic [2*HALF:0]      mask
);

  generate
    for (genvar gi = 0; gi <= 2 * HALF; gi++) begin : g_seg
      localparam int OFS = gi - HALF;
      if (TIP_ONLY) begin : g_tip
        assign mask[gi] = (int'(level) == OFS);
      end else if (OFS > 0) begin : g_pos
        assign mask[gi] = (int'(level) >= OFS);
      end else if (OFS < 0) begin : g_neg
        assign mask[gi] = (int'(level) <= OFS);
      end else begin : g_ctr
        assign mask[gi] = 1'b1;
      end
    end
  endgenerate

endmodule

// File: rtl/signed_bar_display.sv
// Registered signed LED bar driver with saturation, optional one-segment-per-tick
// slewing and a peak-hold marker that decays after a timed hold.
module signed_bar_display
  import signed_bar_pkg::*;
#(
  parameter int W          = 3,
  parameter int HALF       = 3,
  parameter int TICK_DIV   = 4,
  parameter int HOLD_TICKS = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [W-1:0]    d_in,
  input  logic            d_valid,
  input  logic            slew_en,
  input  logic            peak_en,
  output logic [2*HALF:0] d_out,
  output logic            settled
);

  localparam int LW = level_width(HALF);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int HW = $clog2(HOLD_TICKS + 1);

  typedef logic signed [LW-1:0] level_t;

  level_t      target_reg, cur_reg, peak_reg;
  level_t      mapped, cur_step, peak_step;
  logic [PW-1:0] presc_reg;
  logic [HW-1:0] hold_reg;
  peak_state_t state_reg;
  logic        peak_en_reg;
  logic        tick, capture;
  int          mapped_int, cur_mag, peak_mag;
  logic [2*HALF:0] bar_mask_w, tip_mask_w;

  always_comb begin
    mapped_int = map_level(int'($signed(d_in)), W, HALF);
    cur_mag    = (cur_reg < 0) ? -int'(cur_reg) : int'(cur_reg);
    peak_mag   = (peak_reg < 0) ? -int'(peak_reg) : int'(peak_reg);
  end

  assign mapped    = level_t'(mapped_int);
  assign tick      = (presc_reg == PW'(TICK_DIV - 1));
  assign capture   = (cur_mag > peak_mag);
  assign cur_step  = (target_reg > cur_reg) ? cur_reg + level_t'(1) : cur_reg - level_t'(1);
  assign peak_step = (cur_reg > peak_reg) ? peak_reg + level_t'(1) : peak_reg - level_t'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_reg  <= '0;
      target_reg <= '0;
      cur_reg    <= '0;
    end else begin
      presc_reg <= tick ? '0 : presc_reg + PW'(1);
      if (d_valid) target_reg <= mapped;
      // Slew compares against the pre-edge target, so a new target waits a tick.
      if (!slew_en) cur_reg <= d_valid ? mapped : target_reg;
      else if (tick && cur_reg != target_reg) cur_reg <= cur_step;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak_reg    <= '0;
      hold_reg    <= '0;
      state_reg   <= PK_TRACK;
      peak_en_reg <= 1'b0;
    end else begin
      peak_en_reg <= peak_en;
      if (!peak_en) begin
        peak_reg  <= cur_reg;
        state_reg <= PK_TRACK;
      end else if (capture) begin
        peak_reg  <= cur_reg;
        hold_reg  <= HW'(HOLD_TICKS);
        state_reg <= PK_HOLD;
      end else begin
        case (state_reg)
          PK_TRACK: peak_reg <= cur_reg;
          PK_HOLD: begin
            if (tick) begin
              hold_reg <= hold_reg - 1'b1;
              if (hold_reg == HW'(1)) state_reg <= PK_DECAY;
            end
          end
          PK_DECAY: begin
            if (peak_reg == cur_reg) state_reg <= PK_TRACK;
            else if (tick) peak_reg <= peak_step;
          end
          default: state_reg <= PK_TRACK;
        endcase
      end
    end
  end

  bar_mask #(.HALF(HALF), .LW(LW), .TIP_ONLY(1'b0)) u_bar (
    .level (cur_reg),
    .mask  (bar_mask_w)
  );

  bar_mask #(.HALF(HALF), .LW(LW), .TIP_ONLY(1'b1)) u_tip (
    .level (peak_reg),
    .mask  (tip_mask_w)
  );

  assign d_out   = bar_mask_w | (peak_en_reg ? tip_mask_w : '0);
  assign settled = (cur_reg == target_reg);

endmodule

// File: tb/tb_signed_bar_display.sv
// Directed plus randomized bench for signed_bar_display against an
// integer-level reference model of the bar, slew and peak rules.
module tb_signed_bar_display;

  localparam int HALF  = 3;
  localparam int TDIV  = 4;
  localparam int HOLDT = 2;
  localparam int ST_TRACK = 0, ST_HOLD = 1, ST_DECAY = 2;
  localparam logic [6:0] CODE_EXP [8] = '{7'b0001000, 7'b0011000, 7'b0111000, 7'b1111000,
                                          7'b0001000, 7'b0001111, 7'b0001110, 7'b0001100};

  logic       clk, rst_n, d_valid, slew_en, peak_en;
  logic [2:0] d_in;
  logic [4:0] d_in5;
  logic [6:0] d_out, d_out5;
  logic       settled, settled5;

  int checks = 0;
  int errors = 0;
  int m_target, m_cur, m_peak, m_hold, m_presc, m_state;
  bit m_pen;

  signed_bar_display #(.W(3), .HALF(HALF), .TICK_DIV(TDIV), .HOLD_TICKS(HOLDT)) dut (
    .clk(clk), .rst_n(rst_n), .d_in(d_in), .d_valid(d_valid), .slew_en(slew_en),
    .peak_en(peak_en), .d_out(d_out), .settled(settled));

  signed_bar_display #(.W(5), .HALF(HALF), .TICK_DIV(TDIV), .HOLD_TICKS(HOLDT)) dut5 (
    .clk(clk), .rst_n(rst_n), .d_in(d_in5), .d_valid(d_valid), .slew_en(slew_en),
    .peak_en(peak_en), .d_out(d_out5), .settled(settled5));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int iabs(input int x);
    return (x < 0) ? -x : x;
  endfunction

  function automatic int map_raw(input int raw, input int w);
    int v;
    v = (raw >= (1 << (w - 1))) ? raw - (1 << w) : raw;
    if (v == -(1 << (w - 1))) return 0;
    if (v > HALF) return HALF;
    if (v < -HALF) return -HALF;
    return v;
  endfunction

  function automatic logic [6:0] exp_bar(input int cur, input int peak, input bit pen);
    logic [6:0] r;
    r = '0;
    for (int i = 0; i <= 2 * HALF; i++) begin
      int pos;
      pos = i - HALF;
      if (pos == 0) r[i] = 1'b1;
      if (cur > 0 && pos > 0 && pos <= cur) r[i] = 1'b1;
      if (cur < 0 && pos < 0 && pos >= cur) r[i] = 1'b1;
      if (pen && pos == peak) r[i] = 1'b1;
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_target = 0; m_cur = 0; m_peak = 0; m_hold = 0; m_presc = 0;
    m_state = ST_TRACK; m_pen = 0;
  endtask

  task automatic model_step(input bit dv, input int raw, input bit slew, input bit pen);
    int lvl, n_t, n_c, n_p, n_h, n_s;
    bit tk;
    tk  = (m_presc == TDIV - 1);
    lvl = map_raw(raw, 3);
    n_t = dv ? lvl : m_target;
    if (!slew) n_c = dv ? lvl : m_target;
    else if (tk && m_cur != m_target) n_c = m_cur + ((m_target > m_cur) ? 1 : -1);
    else n_c = m_cur;
    n_p = m_peak; n_h = m_hold; n_s = m_state;
    if (!pen) begin
      n_p = m_cur; n_s = ST_TRACK;
    end else if (iabs(m_cur) > iabs(m_peak)) begin
      n_p = m_cur; n_h = HOLDT; n_s = ST_HOLD;
    end else if (m_state == ST_TRACK) begin
      n_p = m_cur;
    end else if (m_state == ST_HOLD) begin
      if (tk) begin
        n_h = m_hold - 1;
        if (n_h == 0) n_s = ST_DECAY;
      end
    end else begin
      if (m_peak == m_cur) n_s = ST_TRACK;
      else if (tk) n_p = m_peak + ((m_cur > m_peak) ? 1 : -1);
    end
    m_target = n_t; m_cur = n_c; m_peak = n_p; m_hold = n_h; m_state = n_s;
    m_presc = (m_presc + 1) % TDIV;
    m_pen = pen;
  endtask

  // One clock: drive inputs, advance the model at the edge, check just after it.
  task automatic cycle(input bit dv, input int raw, input bit slew, input bit pen);
    d_valid = dv; d_in = raw[2:0]; slew_en = slew; peak_en = pen;
    @(posedge clk);
    model_step(dv, raw, slew, pen);
    #1;
    check("d_out", {25'b0, d_out}, {25'b0, exp_bar(m_cur, m_peak, m_pen)});
    check("settled", {31'b0, settled}, {31'b0, (m_cur == m_target)});
  endtask

  initial begin
    int n;
    rst_n = 1'b0; d_valid = 0; d_in = 0; d_in5 = 0; slew_en = 0; peak_en = 0;
    model_reset();
    #2;
    check("reset_d_out", {25'b0, d_out}, 32'h08);
    check("reset_settled", {31'b0, settled}, 32'h1);
    #10 rst_n = 1'b1;

    // Direct mode over every 3-bit code against the literal bar table.
    for (int c = 0; c < 8; c++) begin
      cycle(1, c, 0, 0);
      check($sformatf("code_%0d", c), {25'b0, d_out}, {25'b0, CODE_EXP[c]});
    end

    // Wider sample: saturation and the invalid most-negative code.
    d_in5 = 5'd9;      cycle(1, 0, 0, 0); check("w5_pos9", {25'b0, d_out5}, 32'h78);
    d_in5 = 5'b10111;  cycle(1, 0, 0, 0); check("w5_neg9", {25'b0, d_out5}, 32'h0F);
    d_in5 = 5'b10000;  cycle(1, 0, 0, 0); check("w5_invalid", {25'b0, d_out5}, 32'h08);

    // Slew from 0 to +3, then to -2 through the centre.
    cycle(1, 3, 1, 0);
    n = 0;
    while (m_cur != m_target && n < 40) begin cycle(0, 0, 1, 0); n++; end
    check("slew_up_bound", {31'b0, n <= 16}, 32'h1);
    check("slew_up_bar", {25'b0, d_out}, 32'h78);
    cycle(1, 6, 1, 0);
    n = 0;
    while (m_cur != m_target && n < 60) begin cycle(0, 0, 1, 0); n++; end
    check("slew_dn_bound", {31'b0, n <= 24}, 32'h1);
    check("slew_dn_bar", {25'b0, d_out}, 32'h0E);

    // Peak hold: +3 then 0 leaves the marker on the top segment.
    cycle(1, 0, 0, 1); cycle(1, 0, 0, 1);
    cycle(1, 3, 0, 1);
    cycle(1, 0, 0, 1);
    check("peak_hold_bar", {25'b0, d_out}, 32'h48);
    n = 0;
    while (m_state != ST_TRACK && n < 40) begin cycle(0, 0, 0, 1); n++; end
    check("peak_decayed", {25'b0, d_out}, 32'h08);

    // Recapture during decay, with the new sample landing on a tick edge.
    cycle(1, 3, 0, 1); cycle(1, 0, 0, 1);
    n = 0;
    while (!(m_state == ST_DECAY && m_presc == TDIV - 1) && n < 60) begin
      cycle(0, 0, 0, 1); n++;
    end
    check("reach_decay_tick", {31'b0, n < 60}, 32'h1);
    cycle(1, 3, 0, 1);
    cycle(0, 0, 0, 1);
    check("recapture_bar", {25'b0, d_out}, 32'h78);
    cycle(1, 0, 0, 1);
    check("recapture_hold", {25'b0, d_out}, 32'h48);

    // Asynchronous reset in the middle of the hold.
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_d_out", {25'b0, d_out}, 32'h08);
    check("async_rst_settled", {31'b0, settled}, 32'h1);
    model_reset();
    #2 rst_n = 1'b1;

    // Randomized traffic with occasional mode changes.
    begin
      bit slew, pen;
      slew = 0; pen = 0;
      for (int i = 0; i < 600; i++) begin
        if ($urandom_range(0, 19) == 0) slew = ~slew;
        if ($urandom_range(0, 29) == 0) pen = ~pen;
        cycle($urandom_range(0, 2) == 0, int'($urandom_range(0, 7)), slew, pen);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
